// File: rtl/o_serializer_ds_drv_if.sv
// o_serializer_ds_drv_if: parallel word valid/ready handshake into the output serializer
interface o_serializer_ds_drv_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] d;
    logic             data_valid;
    logic             data_ready;
    modport master (output d, data_valid, input data_ready);
    modport slave (input d, data_valid, output data_ready);
endinterface

// File: rtl/o_serializer_ds_drv.sv
// o_serializer_ds_drv: one-word hold buffer plus shifter driving the serial input of the differential output buffer
module o_serializer_ds_drv #(
    parameter int    WIDTH      = 4,
    parameter string BIT_ORDER  = "MSB_FIRST",
    parameter string IDLE_LEVEL = "LOW"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    o_serializer_ds_drv_if.slave din,
    output logic                 q,
    output logic                 active
);
    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $fatal(1, "%m: WIDTH=%0d illegal; legal range 3..10", WIDTH);
    end
    if (BIT_ORDER != "MSB_FIRST" && BIT_ORDER != "LSB_FIRST") begin : g_bad_order
        $fatal(1, "%m: BIT_ORDER=%s illegal; legal values MSB_FIRST, LSB_FIRST", BIT_ORDER);
    end
    if (IDLE_LEVEL != "LOW" && IDLE_LEVEL != "HIGH") begin : g_bad_idle
        $fatal(1, "%m: IDLE_LEVEL=%s illegal; legal values LOW, HIGH", IDLE_LEVEL);
    end

    localparam int   CW     = $clog2(WIDTH);
    localparam logic IDLE_Q = IDLE_LEVEL == "HIGH";
    localparam bit   MSB    = BIT_ORDER == "MSB_FIRST";

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shifter;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;

    assign din.data_ready = rst_n & ~hold_full;
    assign last = cnt == CW'(WIDTH - 1);
    // a held word may only enter the shifter as the previous word's last bit goes out
    assign load = hold_full & en & (state == IDLE | last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            shifter   <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            q         <= IDLE_Q;
            active    <= 1'b0;
        end else begin
            if (din.data_valid && din.data_ready) begin
                hold      <= din.d;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                shifter <= MSB ? hold << 1 : hold >> 1;
                q       <= MSB ? hold[WIDTH-1] : hold[0];
                cnt     <= '0;
                state   <= SHIFT;
                active  <= 1'b1;
            end else if (state == SHIFT) begin
                if (last) begin
                    q      <= IDLE_Q;
                    active <= 1'b0;
                    state  <= IDLE;
                end else begin
                    q       <= MSB ? shifter[WIDTH-1] : shifter[0];
                    shifter <= MSB ? shifter << 1 : shifter >> 1;
                    cnt     <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
